// File: rtl/wb_master_pkg.sv
// Shared types and default sizes for the Wishbone command master.
package wb_master_pkg;

  localparam int WB_ADDR_W          = 32;
  localparam int WB_DATA_W          = 32;
  localparam int WB_TIMEOUT_CYCLES  = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating wait counter: clear restarts at 0, en counts one per cycle.
// Latency: expired is combinational from the count; expires on the TIMEOUT_CYCLES-th enabled cycle.
// Backpressure: none; holds at its ceiling once saturated.
module wb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Count holds the number of cycles already spent, so the current cycle is the last one at T-1.
  assign expired = en && (cnt >= CNT_LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one command -> one WB cycle -> one response (WB_MASTER_TIMEOUT_EN adds ACK timeout).
// Latency: 2 cycles command-to-response with a zero-wait slave; one transaction outstanding.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready, no same-cycle turnaround.
module wb_cmd_master
  import wb_master_pkg::*;
#(
  parameter int ADDR_W         = WB_ADDR_W,
  parameter int DATA_W         = WB_DATA_W,
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [DATA_W/8-1:0] cmd_sel,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                io_bus_CYC,
  output logic                io_bus_STB,
  output logic                io_bus_WE,
  output logic [DATA_W/8-1:0] io_bus_SEL,
  output logic [ADDR_W-1:0]   io_bus_ADR,
  output logic [DATA_W-1:0]   io_bus_DAT_MOSI,
  input  logic                io_bus_ACK,
  input  logic [DATA_W-1:0]   io_bus_DAT_MISO
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_cmd_master: TIMEOUT_CYCLES must be at least 1");
  end

  wb_state_e state, state_nxt;
  logic      accept, take_ack, take_to, timeout;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    take_ack  = 1'b0;
    take_to   = 1'b0;
    case (state)
      ST_IDLE: if (cmd_valid) begin
        state_nxt = ST_BUS;
        accept    = 1'b1;
      end
      // ACK wins over a timeout expiring on the same edge.
      ST_BUS: if (io_bus_ACK) begin
        state_nxt = ST_RESP;
        take_ack  = 1'b1;
      end else if (timeout) begin
        state_nxt = ST_RESP;
        take_to   = 1'b1;
      end
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cmd_ready  = (state == ST_IDLE);
  assign rsp_valid  = (state == ST_RESP);
  assign io_bus_CYC = (state == ST_BUS);
  assign io_bus_STB = (state == ST_BUS);

  always_ff @(posedge clk) begin
    if (reset) begin
      io_bus_WE       <= 1'b0;
      io_bus_SEL      <= '0;
      io_bus_ADR      <= '0;
      io_bus_DAT_MOSI <= '0;
    end else if (accept) begin
      io_bus_WE       <= cmd_we;
      io_bus_SEL      <= cmd_sel;
      io_bus_ADR      <= cmd_addr;
      io_bus_DAT_MOSI <= cmd_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= '0;
    end else if (take_ack) begin
      rsp_rdata <= io_bus_WE ? '0 : io_bus_DAT_MISO;
    end else if (take_to) begin
      rsp_rdata <= '0;
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  logic err_q;

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .en     (state == ST_BUS),
    .expired(timeout)
  );

  always_ff @(posedge clk) begin
    if (reset)         err_q <= 1'b0;
    else if (take_ack) err_q <= 1'b0;
    else if (take_to)  err_q <= 1'b1;
  end

  assign rsp_err = err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master; timeout scenarios run only when WB_MASTER_TIMEOUT_EN is defined.
module tb_wb_cmd_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [3:0]    cmd_sel;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [AW-1:0] adr;
  logic [DW-1:0] mosi, miso;
  logic          ack;

  int n_cmp = 0;
  int n_bad = 0;

  wb_cmd_master #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .io_bus_CYC(cyc), .io_bus_STB(stb), .io_bus_WE(we), .io_bus_SEL(sel),
    .io_bus_ADR(adr), .io_bus_DAT_MOSI(mosi),
    .io_bus_ACK(ack), .io_bus_DAT_MISO(miso)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle; outputs are then sampled and inputs driven for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b0; ack = 1'b0; miso = '0;
    tick(); tick();
    n_cmp++;
    if ({cyc, stb, we, rsp_valid, rsp_err} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got cyc/stb/we/vld/err=%b expected 00000", {cyc, stb, we, rsp_valid, rsp_err});
    end
    n_cmp++;
    if ({sel, adr, mosi, rsp_rdata} !== '0) begin
      n_bad++; $display("FAIL reset_data: got sel=%h adr=%h mosi=%h rdata=%h expected all 0", sel, adr, mosi, rsp_rdata);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_sel = 4'hF;
    cmd_addr = 32'h3000_0004; cmd_wdata = 32'hDEAD_BEEF;
    tick();
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = 4'h0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    n_cmp++;
    if ({cyc, stb, we, sel, adr, mosi, cmd_ready} !== {3'b111, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 1'b0}) begin
      n_bad++; $display("FAIL wr_bus: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h rdy=%b expected 1 1 1 f 30000004 deadbeef 0",
                        cyc, stb, we, sel, adr, mosi, cmd_ready);
    end
    tick();
    n_cmp++;
    if ({cyc, we, sel, adr, mosi, rsp_valid} !== {2'b11, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 1'b0}) begin
      n_bad++; $display("FAIL wr_wait_hold: got cyc=%b we=%b sel=%h adr=%h dat=%h vld=%b", cyc, we, sel, adr, mosi, rsp_valid);
    end
    ack = 1'b1; miso = 32'hFFFF_FFFF;
    tick();
    ack = 1'b0; miso = '0;
    n_cmp++;
    if ({cyc, stb, rsp_valid, rsp_err, rsp_rdata} !== {4'b0010, 32'h0}) begin
      n_bad++; $display("FAIL wr_rsp: got cyc=%b stb=%b vld=%b err=%b rdata=%h expected 0 0 1 0 0", cyc, stb, rsp_valid, rsp_err, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_bad++; $display("FAIL wr_done: got vld=%b rdy=%b expected 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read_hold();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_addr = 32'h3000_0000; cmd_wdata = 32'h0;
    tick();
    // Queue the next command during the held response; it must wait.
    cmd_we = 1'b1; cmd_sel = 4'h3; cmd_addr = 32'h3000_0008; cmd_wdata = 32'hA5A5_5A5A;
    n_cmp++;
    if ({cyc, we, adr, rsp_valid} !== {2'b10, 32'h3000_0000, 1'b0}) begin
      n_bad++; $display("FAIL rd_bus: got cyc=%b we=%b adr=%h vld=%b expected 1 0 30000000 0", cyc, we, adr, rsp_valid);
    end
    ack = 1'b1; miso = 32'h1234_5678;
    tick();
    ack = 1'b0; miso = 32'h0;
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata, cyc} !== {2'b10, 32'h1234_5678, 1'b0}) begin
      n_bad++; $display("FAIL rd_rsp: got vld=%b err=%b rdata=%h cyc=%b expected 1 0 12345678 0", rsp_valid, rsp_err, rsp_rdata, cyc);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({rsp_valid, rsp_rdata, cmd_ready, cyc} !== {1'b1, 32'h1234_5678, 2'b00}) begin
        n_bad++; $display("FAIL rd_hold%0d: got vld=%b rdata=%h rdy=%b cyc=%b expected 1 12345678 0 0", i, rsp_valid, rsp_rdata, cmd_ready, cyc);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, cmd_ready, cyc} !== 3'b010) begin
      n_bad++; $display("FAIL turnaround: got vld=%b rdy=%b cyc=%b expected 0 1 0", rsp_valid, cmd_ready, cyc);
    end
    tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if ({cyc, we, sel, adr, mosi} !== {2'b11, 4'h3, 32'h3000_0008, 32'hA5A5_5A5A}) begin
      n_bad++; $display("FAIL queued_cmd: got cyc=%b we=%b sel=%h adr=%h dat=%h", cyc, we, sel, adr, mosi);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_in_bus();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h3000_0010;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    n_cmp++;
    if (cyc !== 1'b1) begin
      n_bad++; $display("FAIL rst_bus_pre: got cyc=%b expected 1", cyc);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({cyc, stb, rsp_valid, cmd_ready} !== 4'b0001) begin
      n_bad++; $display("FAIL rst_bus: got cyc=%b stb=%b vld=%b rdy=%b expected 0 0 0 1", cyc, stb, rsp_valid, cmd_ready);
    end
    ack = 1'b1; miso = 32'h5555_AAAA;
    tick();
    ack = 1'b0;
    n_cmp++;
    if ({rsp_valid, cyc, cmd_ready} !== 3'b001) begin
      n_bad++; $display("FAIL rst_no_rsp: got vld=%b cyc=%b rdy=%b expected 0 0 1", rsp_valid, cyc, cmd_ready);
    end
  endtask

  task automatic test_timeout();
    int n_bus;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h3000_0020; miso = 32'hFFFF_FFFF;
    tick();
    cmd_valid = 1'b0;
    n_bus = 0;
`ifdef WB_MASTER_TIMEOUT_EN
    while (cyc === 1'b1 && n_bus < 20) begin
      n_bus++;
      tick();
    end
    n_cmp++;
    if (n_bus !== 4) begin
      n_bad++; $display("FAIL to_len: got %0d bus cycles expected 4", n_bus);
    end
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin
      n_bad++; $display("FAIL to_rsp: got vld=%b err=%b rdata=%h expected 1 1 0", rsp_valid, rsp_err, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    // ACK on the expiry edge must win.
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    ack = 1'b1; miso = 32'h0BAD_F00D;
    tick();
    ack = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
      n_bad++; $display("FAIL to_ack_wins: got vld=%b err=%b rdata=%h expected 1 0 0badf00d", rsp_valid, rsp_err, rsp_rdata);
    end
`else
    while (cyc === 1'b1 && n_bus < 12) begin
      n_bus++;
      tick();
    end
    n_cmp++;
    if ({n_bus, cyc, rsp_valid} !== {32'd12, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL no_timeout: got %0d bus cycles cyc=%b vld=%b expected 12 1 0", n_bus, cyc, rsp_valid);
    end
    ack = 1'b1; miso = 32'h0BAD_F00D;
    tick();
    ack = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
      n_bad++; $display("FAIL late_ack: got vld=%b err=%b rdata=%h expected 1 0 0badf00d", rsp_valid, rsp_err, rsp_rdata);
    end
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int rises, highs, rsps;
    logic prev;
    ack = 1'b1; miso = 32'hCAFE_0001;
    tick();
    ack = 1'b0;
    n_cmp++;
    if ({rsp_valid, cyc, cmd_ready} !== 3'b001) begin
      n_bad++; $display("FAIL stray_ack: got vld=%b cyc=%b rdy=%b expected 0 0 1", rsp_valid, cyc, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h3000_0030; rsp_ready = 1'b1; ack = 1'b1;
    rises = 0; highs = 0; rsps = 0; prev = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (cyc && !prev) rises++;
      if (cyc) highs++;
      prev = cyc;
      if (rsp_valid) begin
        rsps++;
        n_cmp++;
        if (rsp_rdata !== 32'hCAFE_0001) begin
          n_bad++; $display("FAIL b2b_rdata: got %h expected cafe0001", rsp_rdata);
        end
      end
      if (i == 8) cmd_valid = 1'b0;
    end
    n_cmp++;
    if ({rises, highs, rsps} !== {32'd3, 32'd3, 32'd3}) begin
      n_bad++; $display("FAIL b2b_count: got rises=%0d highs=%0d rsps=%0d expected 3 3 3", rises, highs, rsps);
    end
    tick();
    ack = 1'b0; rsp_ready = 1'b0;
    n_cmp++;
    if ({cyc, rsp_valid, cmd_ready} !== 3'b001) begin
      n_bad++; $display("FAIL b2b_idle: got cyc=%b vld=%b rdy=%b expected 0 0 1", cyc, rsp_valid, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_hold();
    test_reset_in_bus();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1);
  end

  always @(negedge clk) begin
    if (!reset) assert (cyc == stb);
  end

endmodule
